pspin_pkt_alloc: RTL and testbench

- Upstream neighbour of the HER generator: allocates fixed-size packet slots in PsPIN L2 packet memory for packets leaving the matching engine.
- Hands {slot address, length, tag} to the ingress DMA write path. The DMA completion for that write later feeds the HER generator.
- Slots are returned when PsPIN feedback reports that a handler has finished with a packet address.
- Tracks slot occupancy in a bitmap and exposes status counters to the ctrl regs.

---
 rtl/pspin_pkt_alloc.sv | 104 ++++++++++
 tb/tb_pspin_pkt_alloc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pspin_pkt_alloc.sv
// Packet slot allocator for PsPIN L2 packet memory: hands out fixed-size slots to
// the ingress DMA and reclaims them on handler feedback, with a one-stage descriptor register.
module pspin_pkt_alloc #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    LEN_WIDTH  = 20,
    parameter int                    TAG_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BUF_BASE   = 32'h1C10_0000,
    parameter int                    SLOT_SIZE  = 2048,
    parameter int                    NUM_SLOTS  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LEN_WIDTH-1:0]         s_len,
    input  logic [TAG_WIDTH-1:0]         s_tag,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [ADDR_WIDTH-1:0]        m_addr,
    output logic [LEN_WIDTH-1:0]         m_len,
    output logic [TAG_WIDTH-1:0]         m_tag,
    output logic                         m_valid,
    input  logic                         m_ready,
    input  logic [ADDR_WIDTH-1:0]        f_addr,
    input  logic                         f_valid,
    output logic                         f_ready,
    output logic [$clog2(NUM_SLOTS):0]   stat_free_slots,
    output logic [31:0]                  stat_drop_cnt,
    output logic [31:0]                  stat_bad_free_cnt
);
    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = $clog2(SLOT_SIZE);
    localparam logic [ADDR_WIDTH:0] REGION  = (ADDR_WIDTH+1)'(NUM_SLOTS * SLOT_SIZE);
    localparam logic [LEN_WIDTH:0]  MAX_LEN = (LEN_WIDTH+1)'(SLOT_SIZE);

    logic [NUM_SLOTS-1:0]  used;
    logic [CNT_W-1:0]      free_cnt;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  len_ok;
    logic                  accept;
    logic                  do_alloc;
    logic                  do_drop;
    logic [ADDR_WIDTH-1:0] off;
    logic                  in_range;
    logic                  aligned;
    logic [IDX_W-1:0]      free_idx;
    logic                  do_free;
    logic                  bad_free;

    // Lowest-index free slot; scanning downward lets the smallest index win.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!used[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign s_ready  = (!m_valid || m_ready) && (free_cnt != '0) && !rst;
    assign f_ready  = !rst;
    assign len_ok   = (s_len != '0) && ({1'b0, s_len} <= MAX_LEN);
    assign accept   = s_valid && s_ready;
    assign do_alloc = accept && len_ok;
    assign do_drop  = accept && !len_ok;

    // A free is honoured only for an aligned in-region address of a slot currently in use.
    assign off      = f_addr - BUF_BASE;
    assign in_range = (f_addr >= BUF_BASE) && ({1'b0, off} < REGION);
    assign aligned  = (off[OFF_W-1:0] == '0);
    assign free_idx = off[OFF_W +: IDX_W];
    assign do_free  = f_valid && in_range && aligned && used[free_idx];
    assign bad_free = f_valid && !do_free;

    assign stat_free_slots = free_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            used              <= '0;
            free_cnt          <= CNT_W'(NUM_SLOTS);
            m_valid           <= 1'b0;
            m_addr            <= '0;
            m_len             <= '0;
            m_tag             <= '0;
            stat_drop_cnt     <= '0;
            stat_bad_free_cnt <= '0;
        end else begin
            if (do_alloc) used[alloc_idx] <= 1'b1;
            if (do_free)  used[free_idx]  <= 1'b0;
            free_cnt <= free_cnt - CNT_W'(do_alloc) + CNT_W'(do_free);

            if (do_alloc) begin
                m_valid <= 1'b1;
                m_addr  <= BUF_BASE + (ADDR_WIDTH'(alloc_idx) << OFF_W);
                m_len   <= s_len;
                m_tag   <= s_tag;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (do_drop && (stat_drop_cnt != '1))
                stat_drop_cnt <= stat_drop_cnt + 32'd1;
            if (bad_free && (stat_bad_free_cnt != '1))
                stat_bad_free_cnt <= stat_bad_free_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_pspin_pkt_alloc.sv
// Bench for pspin_pkt_alloc: directed scenarios followed by random traffic, all
// checked each cycle against a slot-set / descriptor-queue reference model.
module tb_pspin_pkt_alloc;
    localparam int          AW   = 32;
    localparam int          LW   = 20;
    localparam int          TW   = 32;
    localparam int          NS   = 64;
    localparam int          SS   = 2048;
    localparam logic [31:0] BASE = 32'h1C10_0000;
    localparam int          DW   = AW + LW + TW;

    logic          clk;
    logic          rst;
    logic [LW-1:0] s_len;
    logic [TW-1:0] s_tag;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    logic [TW-1:0] m_tag;
    logic          m_valid;
    logic          m_ready;
    logic [AW-1:0] f_addr;
    logic          f_valid;
    logic          f_ready;
    logic [6:0]    stat_free_slots;
    logic [31:0]   stat_drop_cnt;
    logic [31:0]   stat_bad_free_cnt;

    pspin_pkt_alloc #(
        .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
        .BUF_BASE(BASE), .SLOT_SIZE(SS), .NUM_SLOTS(NS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_len(s_len), .s_tag(s_tag), .s_valid(s_valid), .s_ready(s_ready),
        .m_addr(m_addr), .m_len(m_len), .m_tag(m_tag), .m_valid(m_valid), .m_ready(m_ready),
        .f_addr(f_addr), .f_valid(f_valid), .f_ready(f_ready),
        .stat_free_slots(stat_free_slots), .stat_drop_cnt(stat_drop_cnt),
        .stat_bad_free_cnt(stat_bad_free_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: set of slots in use plus queue of pending descriptors
    bit             mdl_used[NS];
    logic [DW-1:0]  exp_q[$];
    int unsigned    mdl_drop = 0;
    int unsigned    mdl_bad  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_free();
        int n = 0;
        for (int i = 0; i < NS; i++) if (!mdl_used[i]) n++;
        return n;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < NS; i++) if (!mdl_used[i]) return i;
        return -1;
    endfunction

    task automatic set_in(input bit v, input int len, input logic [31:0] tag,
                          input bit mr, input bit fv, input logic [31:0] fa);
        s_valid = v;
        s_len   = LW'(len);
        s_tag   = tag;
        m_ready = mr;
        f_valid = fv;
        f_addr  = fa;
    endtask

    // One clock: check combinational readies, predict, clock, check registered outputs.
    task automatic step();
        bit            exp_sready, acc, ok, hs, hit;
        int            fidx, k;
        longint        a;
        logic [DW-1:0] d;
        #1;
        exp_sready = ((exp_q.size() == 0) || m_ready) && (count_free() != 0) && !rst;
        check_eq("s_ready", 64'(s_ready), 64'(exp_sready));
        check_eq("f_ready", 64'(f_ready), 64'(!rst));
        acc  = s_valid && exp_sready;
        ok   = (s_len >= 1) && (s_len <= SS);
        hs   = (exp_q.size() != 0) && m_ready && !rst;
        a    = longint'(f_addr);
        hit  = 1'b0;
        fidx = 0;
        if (f_valid && a >= longint'(BASE) && a < longint'(BASE) + NS * SS
            && ((a - longint'(BASE)) % SS) == 0) begin
            fidx = int'((a - longint'(BASE)) / SS);
            hit  = mdl_used[fidx];
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < NS; i++) mdl_used[i] = 1'b0;
            exp_q.delete();
            mdl_drop = 0;
            mdl_bad  = 0;
        end else begin
            if (hs) void'(exp_q.pop_front());
            if (acc && ok) begin
                k = first_free();
                mdl_used[k] = 1'b1;
                exp_q.push_back({BASE + 32'(k * SS), s_len, s_tag});
            end
            if (acc && !ok) mdl_drop++;
            if (hit) mdl_used[fidx] = 1'b0;
            else if (f_valid) mdl_bad++;
        end
        check_eq("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            d = exp_q[0];
            check_eq("m_addr", 64'(m_addr), 64'(d[DW-1 -: AW]));
            check_eq("m_len",  64'(m_len),  64'(d[TW +: LW]));
            check_eq("m_tag",  64'(m_tag),  64'(d[TW-1:0]));
        end
        check_eq("free_slots", 64'(stat_free_slots), 64'(count_free()));
        check_eq("drop_cnt",   64'(stat_drop_cnt),   64'(mdl_drop));
        check_eq("bad_free",   64'(stat_bad_free_cnt), 64'(mdl_bad));
    endtask

    initial begin
        int r;
        rst = 1'b1;
        set_in(0, 0, 0, 1, 0, 0);
        step();
        step();
        check_eq("rst_addr", 64'(m_addr), 64'h0);
        check_eq("rst_free", 64'(stat_free_slots), 64'd64);
        rst = 1'b0;

        // three requests, 1-cycle latency, consecutive slots
        set_in(1, 64, 32'hA, 1, 0, 0);   step(); check_eq("t1_addr0", 64'(m_addr), 64'h1C100000);
        set_in(1, 1500, 32'hB, 1, 0, 0); step(); check_eq("t1_addr1", 64'(m_addr), 64'h1C100800);
        set_in(1, 2048, 32'hC, 1, 0, 0); step(); check_eq("t1_addr2", 64'(m_addr), 64'h1C101000);
        check_eq("t1_tag2", 64'(m_tag), 64'hC);
        set_in(0, 0, 0, 1, 0, 0);        step(); check_eq("t1_free", 64'(stat_free_slots), 64'd61);

        // fill, stall on full, free one slot and reuse it
        for (int i = 0; i < 61; i++) begin
            set_in(1, 100, 32'(i), 1, 0, 0);
            step();
        end
        set_in(1, 100, 32'h55, 1, 0, 0); step(); check_eq("t2_full_sready", 64'(s_ready), 64'd0);
        set_in(1, 100, 32'h66, 1, 1, 32'h1C100800); step();
        set_in(1, 100, 32'h66, 1, 0, 0); step(); check_eq("t2_reuse_addr", 64'(m_addr), 64'h1C100800);
        set_in(0, 0, 0, 1, 0, 0);        step(); check_eq("t2_refull", 64'(stat_free_slots), 64'd0);

        // bad lengths are consumed and counted
        set_in(0, 0, 0, 1, 1, 32'h1C100000); step();
        set_in(1, 0, 32'h1, 1, 0, 0);        step();
        set_in(1, 2049, 32'h2, 1, 0, 0);     step();
        set_in(0, 0, 0, 1, 0, 0);            step();
        check_eq("t3_drop", 64'(stat_drop_cnt), 64'd2);
        check_eq("t3_mvalid", 64'(m_valid), 64'd0);

        // misaligned, out of range, double free
        set_in(0, 0, 0, 1, 1, 32'h1C100804); step();
        set_in(0, 0, 0, 1, 1, 32'h1C120000); step();
        set_in(0, 0, 0, 1, 1, 32'h1C100000); step();
        set_in(0, 0, 0, 1, 0, 0);            step();
        check_eq("t4_bad", 64'(stat_bad_free_cnt), 64'd3);
        check_eq("t4_free", 64'(stat_free_slots), 64'd1);

        // backpressure hold, then handoff and reload in the same cycle
        set_in(0, 0, 0, 1, 1, 32'h1C101000); step();
        set_in(1, 300, 32'h77, 0, 0, 0);     step();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 400, 32'h88, 0, 0, 0);
            step();
            check_eq("t5_hold_addr", 64'(m_addr), 64'h1C100000);
        end
        set_in(1, 400, 32'h88, 1, 0, 0); step();
        check_eq("t5_reload_addr", 64'(m_addr), 64'h1C101000);

        // alloc and free of a different slot in the same cycle
        set_in(0, 0, 0, 1, 1, 32'h1C101800);       step();
        set_in(1, 500, 32'h99, 1, 1, 32'h1C102000); step();
        check_eq("t6_free", 64'(stat_free_slots), 64'd1);
        check_eq("t6_addr", 64'(m_addr), 64'h1C101800);

        // reset mid-stream with a pending descriptor
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0); step();
        rst = 1'b0;
        check_eq("t7_mvalid", 64'(m_valid), 64'd0);
        check_eq("t7_free", 64'(stat_free_slots), 64'd64);
        set_in(1, 64, 32'h1, 1, 0, 0); step();
        check_eq("t7_addr", 64'(m_addr), 64'h1C100000);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            s_valid = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 9);
            if (r == 0)      s_len = '0;
            else if (r == 1) s_len = LW'($urandom_range(2049, 100000));
            else             s_len = LW'($urandom_range(1, 2048));
            s_tag   = $urandom;
            m_ready = ($urandom_range(0, 9) < 7);
            f_valid = ($urandom_range(0, 9) < 4);
            r = $urandom_range(0, 9);
            if (r == 0)      f_addr = BASE + 32'($urandom_range(0, NS - 1) * SS) + 32'($urandom_range(1, SS - 1));
            else if (r == 1) f_addr = BASE + 32'(NS * SS) + 32'($urandom_range(0, 8) * SS);
            else if (r == 2) f_addr = BASE - 32'($urandom_range(1, 4) * SS);
            else             f_addr = BASE + 32'($urandom_range(0, NS - 1) * SS);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
